matrix_mul: RTL and testbench

//  - Pipelined unsigned integer matrix multiplier: Y = A * B, square N x N operands.
//  - Fully parallel datapath; accepts one matrix pair per clock.
//  - Sits as a compute leaf behind a valid-qualified operand source.
//  - Consumers sample Y when out_valid is high.

---
 rtl/matrix_mul_pkg.sv | 11 +
 rtl/matrix_mul_dot.sv | 18 +
 rtl/matrix_mul.sv | 72 +++++++
 tb/tb_matrix_mul.sv | 119 +++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// matrix_mul_pkg: shared defaults, element types and flat-index helper for matrix_mul.
package matrix_mul_pkg;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int OW = 16;
  typedef logic [DW-1:0] elem_t;
  typedef logic [OW-1:0] res_t;
  function automatic int idx(input int i, input int j);
    return i * N + j;
  endfunction
endpackage

// File: rtl/matrix_mul_dot.sv
// matrix_mul_dot: combinational N-term unsigned dot product of one A row and one B column.
module matrix_mul_dot
  import matrix_mul_pkg::*;
#(
  parameter int N  = matrix_mul_pkg::N,
  parameter int DW = matrix_mul_pkg::DW,
  parameter int OW = matrix_mul_pkg::OW
) (
  input  logic [N*DW-1:0] row_i,
  input  logic [N*DW-1:0] col_i,
  output logic [OW-1:0]   dot_o
);
  always_comb begin
    dot_o = '0;
    for (int k = 0; k < N; k++)
      dot_o = dot_o + OW'({{DW{1'b0}}, row_i[k*DW +: DW]} * {{DW{1'b0}}, col_i[k*DW +: DW]});
  end
endmodule

// File: rtl/matrix_mul.sv
// matrix_mul: pipelined unsigned N x N matrix multiplier, Y = A * B, one pair per clock.
// Define MATRIX_MUL_OUTREG_EN to add a third output register stage (latency 3).
module matrix_mul
  import matrix_mul_pkg::*;
#(
  parameter int N  = matrix_mul_pkg::N,
  parameter int DW = matrix_mul_pkg::DW,
  parameter int OW = matrix_mul_pkg::OW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N*N*DW-1:0] a_i,
  input  logic [N*N*DW-1:0] b_i,
  output logic              out_valid,
  output logic [N*N*OW-1:0] y_o
);
  localparam int MW = N * N * DW;
  localparam int YW = N * N * OW;
  logic          v1_q, v2_q;
  logic [MW-1:0] a_q, b_q;
  logic [YW-1:0] y_d, y2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      y2_q <= '0;
    end else begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (v1_q) y2_q <= y_d;
    end
  end
  // Row i of A is contiguous in the flat packing; column j of B is gathered with stride N.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [N*DW-1:0] col;
      for (genvar k = 0; k < N; k++) begin : g_k
        assign col[k*DW +: DW] = b_q[(k*N+j)*DW +: DW];
      end
      matrix_mul_dot #(.N(N), .DW(DW), .OW(OW)) u_dot (
        .row_i(a_q[i*N*DW +: N*DW]),
        .col_i(col),
        .dot_o(y_d[(i*N+j)*OW +: OW])
      );
    end
  end
`ifdef MATRIX_MUL_OUTREG_EN
  logic          v3_q;
  logic [YW-1:0] y3_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      y3_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) y3_q <= y2_q;
    end
  end
  assign out_valid = v3_q;
  assign y_o       = y3_q;
`else
  assign out_valid = v2_q;
  assign y_o       = y2_q;
`endif
endmodule

// File: tb/tb_matrix_mul.sv
// tb_matrix_mul: directed self-checking bench for matrix_mul.
module tb_matrix_mul;
  import matrix_mul_pkg::*;
  localparam int MW = N * N * DW;
  localparam int YW = N * N * OW;
`ifdef MATRIX_MUL_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [MW-1:0] a = '0, b = '0;
  logic          out_valid;
  logic [YW-1:0] y;
  int checks = 0, passed = 0, fails = 0;
  always #5 clk = ~clk;
  matrix_mul #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a_i(a), .b_i(b), .out_valid(out_valid), .y_o(y)
  );
  function automatic logic [YW-1:0] model(input logic [MW-1:0] x, input logic [MW-1:0] z);
    logic [YW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(x[idx(i,k)*DW +: DW]) * int'(z[idx(k,j)*DW +: DW]);
        r[idx(i,j)*OW +: OW] = OW'(s);
      end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [MW-1:0] x, input logic [MW-1:0] z);
    a = x;
    b = z;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  logic [MW-1:0] id_a, id_b, qa [5], qb [5];
  logic [YW-1:0] id_y;
  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        id_a[idx(i,j)*DW +: DW] = DW'(i == j);
        id_b[idx(i,j)*DW +: DW] = DW'(i * 4 + j);
        id_y[idx(i,j)*OW +: OW] = OW'(i * 4 + j);
      end
    repeat (2) @(negedge clk);
    chk("reset_valid", YW'(out_valid), '0);
    chk("reset_y", y, '0);
    rst_n = 1'b1;
    @(negedge clk);
    send(id_a, id_b);
    for (int t = 1; t < LAT; t++) begin
      chk("id_early", YW'(out_valid), '0);
      @(negedge clk);
    end
    chk("id_valid", YW'(out_valid), YW'(1));
    chk("id_y", y, id_y);
    @(negedge clk);
    chk("id_pulse", YW'(out_valid), '0);
    chk("id_hold", y, id_y);
    send('1, '1);
    repeat (LAT - 1) @(negedge clk);
    chk("max_valid", YW'(out_valid), YW'(1));
    chk("max_y", y, {16{16'h0384}});
    send('0, {$urandom, $urandom});
    repeat (LAT - 1) @(negedge clk);
    chk("zero_valid", YW'(out_valid), YW'(1));
    chk("zero_y", y, '0);
    for (int n = 0; n < 5; n++) begin
      qa[n] = {$urandom, $urandom};
      qb[n] = {$urandom, $urandom};
    end
    for (int t = 0; t < 5 + LAT; t++) begin
      if (t >= LAT) begin
        chk("b2b_valid", YW'(out_valid), YW'(1));
        chk("b2b_y", y, model(qa[t-LAT], qb[t-LAT]));
      end
      if (t < 5) begin
        a = qa[t];
        b = qb[t];
      end
      in_valid = (t < 5);
      @(negedge clk);
    end
    chk("b2b_end", YW'(out_valid), '0);
    send(qa[0], qb[0]);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", YW'(out_valid), '0);
    chk("rst_async_y", y, '0);
    @(negedge clk);
    chk("rst_valid", YW'(out_valid), '0);
    chk("rst_y", y, '0);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("rst_discard_valid", YW'(out_valid), '0);
    chk("rst_discard_y", y, '0);
    send(id_a, id_b);
    repeat (LAT - 1) @(negedge clk);
    chk("resume_valid", YW'(out_valid), YW'(1));
    chk("resume_y", y, id_y);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
